// File: rtl/score_bcd_display.sv
// Score/level display driver for the HEX bank.
// A sequential double-dabble converter turns the selected score (live or
// session high) into BCD. The result, the level digit and an 'L'/'H' prefix
// are written to active-low seven-segment registers in a single edge, so the
// displays never show a partially converted value.
module score_bcd_display #(
    parameter int SCORE_W  = 12,
    parameter int LEVEL_W  = 3,
    parameter int DIGITS   = 4,
    parameter int BLANK_LZ = 1
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic [SCORE_W-1:0]        score,
    input  logic [LEVEL_W-1:0]        level,
    input  logic                      show_high,
    output logic [7*(DIGITS+2)-1:0]   hex_out,
    output logic [SCORE_W-1:0]        high_score,
    output logic [LEVEL_W-1:0]        high_level,
    output logic                      busy
);

    // Number of decimal digits needed for the largest SCORE_W-bit value.
    function automatic int bcd_digits(input int w);
        longint v;
        int     d;
        v = (longint'(1) << w) - longint'(1);
        d = 0;
        for (int k = 0; k < 20; k++) begin
            if (v != 0) begin
                v = v / 10;
                d++;
            end
        end
        return d;
    endfunction

    // 10**n as an unsigned 32-bit value (n <= 5 keeps it well in range).
    function automatic logic [31:0] pow10(input int n);
        logic [31:0] v;
        v = 32'd1;
        for (int k = 0; k < n; k++) begin
            v = v * 32'd10;
        end
        return v;
    endfunction

    localparam int          BCD_D     = bcd_digits(SCORE_W);
    localparam int          EXT_D     = (BCD_D > DIGITS) ? BCD_D : DIGITS;
    localparam int          DD_W      = 4 * BCD_D + SCORE_W;
    localparam int          HEX_W     = 7 * (DIGITS + 2);
    localparam int          CNT_W     = $clog2(SCORE_W + 1);
    localparam logic [31:0] SAT_LIMIT = pow10(DIGITS);

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_9     = 7'h18;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_L     = 7'h47;
    localparam logic [6:0] SEG_H     = 7'h09;

    // Active-low segment pattern for one decimal digit; anything else is blank.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h18;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Display image for a zero score, level 0, live ('L') prefix.
    function automatic logic [HEX_W-1:0] reset_hex();
        logic [HEX_W-1:0] h;
        h = '0;
        h[6:0] = SEG_0;
        for (int i = 1; i < DIGITS; i++) begin
            h[7*i +: 7] = (BLANK_LZ != 0) ? SEG_BLANK : SEG_0;
        end
        h[7*DIGITS +: 7]     = SEG_0;
        h[7*(DIGITS+1) +: 7] = SEG_L;
        return h;
    endfunction

    localparam logic [HEX_W-1:0] HEX_RST = reset_hex();

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t               r_state;
    state_t               w_next_state;

    logic [SCORE_W-1:0]   r_high_score;
    logic [LEVEL_W-1:0]   r_high_level;

    // Tuple most recently written to the displays.
    logic                 r_last_hi;
    logic [SCORE_W-1:0]   r_last_score;
    logic [LEVEL_W-1:0]   r_last_level;

    // Tuple being converted, frozen for the whole conversion.
    logic                 r_src_hi;
    logic [SCORE_W-1:0]   r_src_score;
    logic [LEVEL_W-1:0]   r_src_level;

    // Double-dabble register: BCD digits on top, binary being shifted out below.
    logic [DD_W-1:0]      r_dd;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_cool;
    logic [HEX_W-1:0]     r_hex;

    logic [SCORE_W-1:0]   w_src_score;
    logic [LEVEL_W-1:0]   w_src_level;
    logic                 w_changed;
    logic                 w_start;
    logic                 w_last_step;
    logic [DD_W-1:0]      w_dd_adj;
    logic [4*EXT_D-1:0]   w_bcd_ext;
    logic                 w_saturate;
    logic [HEX_W-1:0]     w_hex_new;

    assign w_src_score = show_high ? r_high_score : score;
    assign w_src_level = show_high ? r_high_level : level;
    assign w_changed   = {show_high, w_src_score, w_src_level}
                         != {r_last_hi, r_last_score, r_last_level};
    // The cycle right after a display update is a forced IDLE cycle, which
    // spaces successive updates by at least SCORE_W+3 edges.
    assign w_start     = w_changed && !r_cool;
    assign w_last_step = (r_cnt == CNT_W'(SCORE_W - 1));
    assign w_saturate  = 32'(r_src_score) >= SAT_LIMIT;

    assign hex_out     = r_hex;
    assign high_score  = r_high_score;
    assign high_level  = r_high_level;
    assign busy        = (r_state != IDLE);

    // Session high score and high level, cleared only by reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            // NOTE: every clocked register uses non-blocking assignments so all
            // flops sample the values from before the edge, independent of order.
            r_high_score <= '0;
            r_high_level <= '0;
        end else begin
            if (score > r_high_score) begin
                r_high_score <= score;
            end
            if (level > r_high_level) begin
                r_high_level <= level;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        // NOTE: default assignment first; a path that left w_next_state
        // unassigned would infer a latch.
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next_state = SHIFT;
            SHIFT:   if (w_last_step) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Double-dabble correction: add 3 to every BCD digit that is 5 or more.
    always_comb begin
        w_dd_adj = r_dd;
        for (int d = 0; d < BCD_D; d++) begin
            if (r_dd[SCORE_W + 4*d +: 4] >= 4'd5) begin
                w_dd_adj[SCORE_W + 4*d +: 4] = r_dd[SCORE_W + 4*d +: 4] + 4'd3;
            end
        end
    end

    // Build the new display image from the finished BCD result.
    always_comb begin
        logic       lit;
        logic [3:0] dig;
        w_bcd_ext              = '0;
        w_bcd_ext[4*BCD_D-1:0] = r_dd[DD_W-1:SCORE_W];
        w_hex_new              = '0;
        lit                    = 1'b0;
        dig                    = 4'd0;
        // Walk from the most significant display down so 'lit' marks the first
        // nonzero digit; everything above it is a leading zero.
        for (int i = DIGITS - 1; i >= 0; i--) begin
            dig = w_bcd_ext[4*i +: 4];
            if (dig != 4'd0) begin
                lit = 1'b1;
            end
            if (w_saturate) begin
                w_hex_new[7*i +: 7] = SEG_9;
            end else if ((BLANK_LZ != 0) && !lit && (i != 0)) begin
                w_hex_new[7*i +: 7] = SEG_BLANK;
            end else begin
                w_hex_new[7*i +: 7] = seg7(dig);
            end
        end
        w_hex_new[7*DIGITS +: 7]     = seg7(4'(r_src_level));
        w_hex_new[7*(DIGITS+1) +: 7] = r_src_hi ? SEG_H : SEG_L;
    end

    // Conversion datapath and display registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_last_hi    <= 1'b0;
            r_last_score <= '0;
            r_last_level <= '0;
            r_src_hi     <= 1'b0;
            r_src_score  <= '0;
            r_src_level  <= '0;
            r_dd         <= '0;
            r_cnt        <= '0;
            r_cool       <= 1'b0;
            r_hex        <= HEX_RST;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cool <= 1'b0;
                    if (w_start) begin
                        r_src_hi    <= show_high;
                        r_src_score <= w_src_score;
                        r_src_level <= w_src_level;
                        r_dd        <= DD_W'(w_src_score);
                        r_cnt       <= '0;
                    end
                end
                SHIFT: begin
                    // Shifting the whole register moves the next binary bit
                    // into the BCD units digit.
                    r_dd  <= w_dd_adj << 1;
                    r_cnt <= r_cnt + 1'b1;
                end
                DONE: begin
                    r_hex        <= w_hex_new;
                    r_last_hi    <= r_src_hi;
                    r_last_score <= r_src_score;
                    r_last_level <= r_src_level;
                    r_cool       <= 1'b1;
                end
                default: begin
                    r_cool <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_bcd_display.sv
// Bench for score_bcd_display: three instances (default, DIGITS=3, BLANK_LZ=0)
// share one stimulus. Expected display images go into a queue when stimulus is
// issued; a monitor pops and compares whenever a conversion finishes.
module tb_score_bcd_display;

    logic        clock = 1'b0;
    logic        resetn;
    logic [11:0] score;
    logic [2:0]  level;
    logic        show_high;

    logic [41:0] hex_a;
    logic [34:0] hex_b;
    logic [41:0] hex_c;
    logic [11:0] hs_a, hs_b, hs_c;
    logic [2:0]  hl_a, hl_b, hl_c;
    logic        busy_a, busy_b, busy_c;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        logic [41:0] a;
        logic [34:0] b;
        logic [41:0] c;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    logic prev_busy = 1'b0;

    always #5 clock = ~clock;

    score_bcd_display #(.SCORE_W(12), .LEVEL_W(3), .DIGITS(4), .BLANK_LZ(1)) dut_a (
        .clock(clock), .resetn(resetn), .score(score), .level(level),
        .show_high(show_high), .hex_out(hex_a), .high_score(hs_a),
        .high_level(hl_a), .busy(busy_a)
    );

    score_bcd_display #(.SCORE_W(12), .LEVEL_W(3), .DIGITS(3), .BLANK_LZ(1)) dut_b (
        .clock(clock), .resetn(resetn), .score(score), .level(level),
        .show_high(show_high), .hex_out(hex_b), .high_score(hs_b),
        .high_level(hl_b), .busy(busy_b)
    );

    score_bcd_display #(.SCORE_W(12), .LEVEL_W(3), .DIGITS(4), .BLANK_LZ(0)) dut_c (
        .clock(clock), .resetn(resetn), .score(score), .level(level),
        .show_high(show_high), .hex_out(hex_c), .high_score(hs_c),
        .high_level(hl_c), .busy(busy_c)
    );

    function automatic logic [41:0] p6(input logic [6:0] p, l, d3, d2, d1, d0);
        return {p, l, d3, d2, d1, d0};
    endfunction

    function automatic logic [34:0] p5(input logic [6:0] p, l, d2, d1, d0);
        return {p, l, d2, d1, d0};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic expect_update(input string tag, input logic [41:0] a,
                                 input logic [34:0] b, input logic [41:0] c);
        exp_t e;
        e.tag = tag;
        e.a   = a;
        e.b   = b;
        e.c   = c;
        sb_q.push_back(e);
    endtask

    // Wait (bounded) until the monitor has consumed every expectation.
    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clock);
            #1;
            n++;
        end
        check({name, "_drained"}, 64'(sb_q.size()), 64'd0);
    endtask

    // Wait (bounded) for busy to rise; ends just after the latching edge.
    task automatic wait_busy(input string name);
        int n;
        n = 0;
        while (!busy_a && n < 40) begin
            @(posedge clock);
            #1;
            n++;
        end
        check({name, "_busy_rise"}, 64'(busy_a), 64'd1);
    endtask

    // Monitor: a falling busy outside reset marks a display update.
    always @(negedge clock) begin
        if (resetn && prev_busy && !busy_a) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_update: got hex %h, expected no update", hex_a);
            end else begin
                mon_e = sb_q.pop_front();
                check({mon_e.tag, "_d4"},   64'(hex_a), 64'(mon_e.a));
                check({mon_e.tag, "_d3"},   64'(hex_b), 64'(mon_e.b));
                check({mon_e.tag, "_nolz"}, 64'(hex_c), 64'(mon_e.c));
            end
        end
        prev_busy <= resetn ? busy_a : 1'b0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [41:0] old_hex;
        int          n, k, k1, k2, busy_cnt;
        logic        pb;

        resetn    = 1'b0;
        score     = '0;
        level     = '0;
        show_high = 1'b0;
        #12;
        check("rst_d4",   64'(hex_a), 64'(p6(7'h47, 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h40)));
        check("rst_d3",   64'(hex_b), 64'(p5(7'h47, 7'h40, 7'h7F, 7'h7F, 7'h40)));
        check("rst_nolz", 64'(hex_c), 64'(p6(7'h47, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40)));
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_high", 64'(hs_a), 64'd0);

        // Release with the reset tuple still on the inputs: nothing converts.
        @(negedge clock);
        resetn = 1'b1;
        busy_cnt = 0;
        repeat (20) begin
            @(posedge clock);
            #1;
            if (busy_a) busy_cnt++;
        end
        check("idle_after_reset", 64'(busy_cnt), 64'd0);

        // 1234, level 2: latency and decimal conversion.
        @(negedge clock);
        #1;
        old_hex = hex_a;
        score = 12'd1234;
        level = 3'd2;
        expect_update("s1234",
                      p6(7'h47, 7'h24, 7'h79, 7'h24, 7'h30, 7'h19),
                      p5(7'h47, 7'h24, 7'h18, 7'h18, 7'h18),
                      p6(7'h47, 7'h24, 7'h79, 7'h24, 7'h30, 7'h19));
        @(posedge clock);
        #1;
        check("busy_after_edge1", 64'(busy_a), 64'd1);
        n = 1;
        while (hex_a == old_hex && n < 40) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("latency_edges", 64'(n), 64'd14);
        check("busy_after_done", 64'(busy_a), 64'd0);
        drain("s1234");

        // Small value: leading-zero blanking versus full display.
        score = 12'd7;
        level = 3'd0;
        expect_update("s7",
                      p6(7'h47, 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h78),
                      p5(7'h47, 7'h40, 7'h7F, 7'h7F, 7'h78),
                      p6(7'h47, 7'h40, 7'h40, 7'h40, 7'h40, 7'h78));
        drain("s7");

        // Fresh session for high-score tracking.
        resetn = 1'b0;
        score  = 12'd500;
        level  = 3'd3;
        #1;
        check("rst2_d4", 64'(hex_a), 64'(p6(7'h47, 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h40)));
        @(negedge clock);
        #1;
        resetn = 1'b1;
        expect_update("s500",
                      p6(7'h47, 7'h30, 7'h7F, 7'h12, 7'h40, 7'h40),
                      p5(7'h47, 7'h30, 7'h12, 7'h40, 7'h40),
                      p6(7'h47, 7'h30, 7'h40, 7'h12, 7'h40, 7'h40));
        drain("s500");
        score = 12'd200;
        level = 3'd1;
        expect_update("s200",
                      p6(7'h47, 7'h79, 7'h7F, 7'h24, 7'h40, 7'h40),
                      p5(7'h47, 7'h79, 7'h24, 7'h40, 7'h40),
                      p6(7'h47, 7'h79, 7'h40, 7'h24, 7'h40, 7'h40));
        drain("s200");
        show_high = 1'b1;
        expect_update("high",
                      p6(7'h09, 7'h30, 7'h7F, 7'h12, 7'h40, 7'h40),
                      p5(7'h09, 7'h30, 7'h12, 7'h40, 7'h40),
                      p6(7'h09, 7'h30, 7'h40, 7'h12, 7'h40, 7'h40));
        drain("high");
        check("high_score", 64'(hs_a), 64'd500);
        check("high_level", 64'(hl_a), 64'd3);

        // Input change during conversion is deferred to the next conversion.
        show_high = 1'b0;
        score     = 12'd10;
        level     = 3'd1;
        expect_update("s10",
                      p6(7'h47, 7'h79, 7'h7F, 7'h7F, 7'h79, 7'h40),
                      p5(7'h47, 7'h79, 7'h7F, 7'h79, 7'h40),
                      p6(7'h47, 7'h79, 7'h40, 7'h40, 7'h79, 7'h40));
        expect_update("s20",
                      p6(7'h47, 7'h79, 7'h7F, 7'h7F, 7'h24, 7'h40),
                      p5(7'h47, 7'h79, 7'h7F, 7'h24, 7'h40),
                      p6(7'h47, 7'h79, 7'h40, 7'h40, 7'h24, 7'h40));
        wait_busy("s10");
        repeat (4) @(posedge clock);
        @(negedge clock);
        #1;
        score = 12'd20;
        k = 0; k1 = -1; k2 = -1; pb = busy_a;
        while (k2 < 0 && k < 100) begin
            @(posedge clock);
            #1;
            k++;
            if (pb && !busy_a) begin
                if (k1 < 0) k1 = k;
                else        k2 = k;
            end
            pb = busy_a;
        end
        n_checks++;
        if (k1 < 0 || k2 < 0 || (k2 - k1) < 15) begin
            n_errors++;
            $display("FAIL update_spacing: got %0d edges, expected at least 15", k2 - k1);
        end
        drain("s20");

        // Reset during SHIFT aborts the conversion.
        score = 12'd30;
        wait_busy("s30");
        repeat (3) @(posedge clock);
        @(negedge clock);
        #1;
        resetn = 1'b0;
        #1;
        check("abort_d4",   64'(hex_a), 64'(p6(7'h47, 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h40)));
        check("abort_d3",   64'(hex_b), 64'(p5(7'h47, 7'h40, 7'h7F, 7'h7F, 7'h40)));
        check("abort_nolz", 64'(hex_c), 64'(p6(7'h47, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40)));
        check("abort_busy", 64'(busy_a), 64'd0);
        check("abort_high", 64'(hs_a), 64'd0);
        @(negedge clock);
        @(negedge clock);
        #1;
        resetn = 1'b1;
        expect_update("s30",
                      p6(7'h47, 7'h79, 7'h7F, 7'h7F, 7'h30, 7'h40),
                      p5(7'h47, 7'h79, 7'h7F, 7'h30, 7'h40),
                      p6(7'h47, 7'h79, 7'h40, 7'h40, 7'h30, 7'h40));
        wait_busy("restart");
        drain("s30");
        check("high_after_restart", 64'(hs_a), 64'd30);

        repeat (20) @(posedge clock);
        check("queue_empty", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
